// File: rtl/pokey_timer_ctrl_if.sv
// Control bundle between the POKEY timer sequencer and its counter chains.
`timescale 1ns/1ps
interface pokey_timer_ctrl_if;
    logic       enn;
    logic [7:0] audctl;
    logic       stimer;
    logic [3:0] nbor;
    logic [3:0] ld;
    logic [3:0] cr;
    logic [3:0] tick_out;

    modport master (
        output enn, audctl, stimer, nbor,
        input  ld, cr, tick_out
    );

    modport slave (
        input  enn, audctl, stimer, nbor,
        output ld, cr, tick_out
    );
endinterface

// File: rtl/pokey_timer_ctrl.sv
// POKEY timer sequencer: base-clock prescalers, per-unit reload FSMs,
// load/count-request strobes and registered underflow ticks.
`timescale 1ns/1ps
module pokey_timer_ctrl #(
    parameter int DIV64      = 28,
    parameter int DIV15      = 114,
    parameter int RELOAD_DLY = 2
) (
    input logic               clk,
    input logic               nrst,
    pokey_timer_ctrl_if.slave bus
);
    localparam int P64W = $clog2(DIV64);
    localparam int P15W = $clog2(DIV15);
    localparam int DW   = (RELOAD_DLY > 2) ? $clog2(RELOAD_DLY) : 1;
    localparam logic [DW-1:0] DLY_INIT =
        DW'((RELOAD_DLY > 0) ? RELOAD_DLY - 1 : 0);

    typedef enum logic [1:0] {S_COUNT, S_WAIT, S_LOAD} state_e;

    state_e          st_q  [4];
    state_e          st_d  [4];
    logic [DW-1:0]   dly_q [4];
    logic [DW-1:0]   dly_d [4];
    logic [P64W-1:0] p64_q, p64_d;
    logic [P15W-1:0] p15_q, p15_d;
    logic [3:0]      tick_q, tick_d;
    logic            t64, t15, base;
    logic [3:0]      src, act, cr, ld;
    logic [1:0]      own [4];
    logic            unused_audctl;

    assign unused_audctl = ^{bus.audctl[7], bus.audctl[2:1]};

    // A linked pair shares the reload unit of its high channel.
    always_comb begin
        t64    = p64_q == P64W'(DIV64 - 1);
        t15    = p15_q == P15W'(DIV15 - 1);
        base   = bus.audctl[0] ? t15 : t64;
        src[0] = bus.audctl[6] | base;
        src[1] = bus.audctl[4] ? ~bus.nbor[0] : base;
        src[2] = bus.audctl[5] | base;
        src[3] = bus.audctl[3] ? ~bus.nbor[2] : base;
        own[0] = bus.audctl[4] ? 2'd1 : 2'd0;
        own[1] = 2'd1;
        own[2] = bus.audctl[3] ? 2'd3 : 2'd2;
        own[3] = 2'd3;
        act    = {1'b1, ~bus.audctl[3], 1'b1, ~bus.audctl[4]};
        cr     = '0;
        ld     = '0;
        for (int i = 0; i < 4; i++) begin
            cr[i] = bus.enn & src[i] & (st_q[own[i]] == S_COUNT);
            ld[i] = st_q[own[i]] == S_LOAD;
        end
    end

    always_comb begin
        p64_d  = p64_q;
        p15_d  = p15_q;
        tick_d = tick_q;
        for (int u = 0; u < 4; u++) begin
            st_d[u]  = st_q[u];
            dly_d[u] = dly_q[u];
        end
        if (bus.enn) begin
            tick_d = ~bus.nbor;
            if (bus.stimer) begin
                p64_d = '0;
                p15_d = '0;
            end else begin
                p64_d = t64 ? '0 : p64_q + 1'b1;
                p15_d = t15 ? '0 : p15_q + 1'b1;
            end
            for (int u = 0; u < 4; u++) begin
                if (bus.stimer) begin
                    st_d[u] = S_LOAD;
                end else begin
                    unique case (st_q[u])
                        S_COUNT: begin
                            if (act[u] && !bus.nbor[u]) begin
                                st_d[u]  = (RELOAD_DLY == 0) ? S_LOAD : S_WAIT;
                                dly_d[u] = DLY_INIT;
                            end
                        end
                        S_WAIT: begin
                            if (dly_q[u] == '0) st_d[u] = S_LOAD;
                            else dly_d[u] = dly_q[u] - 1'b1;
                        end
                        S_LOAD:  st_d[u] = S_COUNT;
                        default: st_d[u] = S_LOAD;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p64_q  <= '0;
            p15_q  <= '0;
            tick_q <= '0;
            for (int u = 0; u < 4; u++) begin
                st_q[u]  <= S_LOAD;
                dly_q[u] <= '0;
            end
        end else begin
            p64_q  <= p64_d;
            p15_q  <= p15_d;
            tick_q <= tick_d;
            for (int u = 0; u < 4; u++) begin
                st_q[u]  <= st_d[u];
                dly_q[u] <= dly_d[u];
            end
        end
    end

    assign bus.cr       = cr;
    assign bus.ld       = ld;
    assign bus.tick_out = tick_q;
endmodule
